de10_sram_controller: RTL and testbench

Slave-side controller for the on-chip SRAM region (address tag 0, bytes 0x0000_0000–0x003F_FFFF) of the DE10 memory map. It sits directly downstream of the bus address decoder, taking that decoder's SRAM enable plus the shared address and write bus. It returns the read word and a ready pulse to the decoder's SRAM data and ready inputs. The storage is an internal word array with configurable wait states, byte-enabled writes and a defined abort path.

---
 rtl/de10_sram_controller.sv | 192 +++++++++++++++++++
 tb/tb_de10_sram_controller.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/de10_sram_controller.sv
// ---------------------------------------------------------------------------
// de10_sram_controller
//
// Slave-side controller for the DE10 on-chip SRAM region. It accepts one
// request at a time from the bus decoder, optionally waits WAIT_STATES
// cycles, then completes the access against an internal word array and
// pulses oready for one cycle.
//
// Handshake: a request is present while ien=1. The master holds ien, iaddr,
// iwe, ibe and iwdata until it observes oready=1. The request fields are
// captured when the request is accepted in IDLE; later changes to them are
// ignored. Dropping ien before completion (while waiting) aborts the access
// with no array write and odata left unchanged. oready is a single-cycle
// pulse and odata is valid from that cycle until the next completion.
//
// Parameters:
//   ADDR_WIDTH  - word-index width; the array holds 2**ADDR_WIDTH words
//   WAIT_STATES - extra cycles between acceptance and completion (0..15)
//
// Ports:
//   clk     - clock, rising-edge
//   rst     - asynchronous active-high reset
//   ien     - request present (SRAM select from the decoder)
//   iaddr   - byte address; word index is iaddr[ADDR_WIDTH+1:2]
//   iwe     - 1 = write, 0 = read
//   ibe     - per-byte write enables (ibe[n] covers bits 8n+7:8n)
//   iwdata  - write data
//   odata   - read word, or merged word after a write
//   oready  - one-cycle completion pulse
// ---------------------------------------------------------------------------
module de10_sram_controller #(
    parameter int ADDR_WIDTH  = 12,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ien,
    input  logic [31:0] iaddr,
    input  logic        iwe,
    input  logic [3:0]  ibe,
    input  logic [31:0] iwdata,
    output logic [31:0] odata,
    output logic        oready
);

    localparam int          DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [3:0]  WS    = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  state;
    state_t                  next_state;
    logic [3:0]              cnt;

    // Request fields captured at acceptance.
    logic [ADDR_WIDTH-1:0]   idx_q;
    logic                    we_q;
    logic [3:0]              be_q;
    logic [31:0]             wdata_q;

    logic                    accept;
    logic                    complete;

    // Fields used at the completing edge. With zero wait states the
    // completion happens on the acceptance edge itself, so the live inputs
    // must be used instead of the (not yet loaded) captured copies.
    logic [ADDR_WIDTH-1:0]   eff_idx;
    logic                    eff_we;
    logic [3:0]              eff_be;
    logic [31:0]             eff_wdata;
    logic [31:0]             cur_word;
    logic [31:0]             merged;

    logic [31:0]             mem [0:DEPTH-1];

    // Address bits that do not select a word are intentionally ignored.
    logic                    unused_addr_bits;
    assign unused_addr_bits = ^{iaddr[31:ADDR_WIDTH+2], iaddr[1:0]};

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (ien) begin
                    next_state = (WS == 4'd0) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!ien) begin
                    next_state = S_IDLE;          // abort
                end else if (cnt == 4'd1) begin
                    next_state = S_DONE;          // counter reaches 0 this edge
                end
            end
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs and control strobes
    // -----------------------------------------------------------------------
    always_comb begin
        oready   = (state == S_DONE);
        accept   = (state == S_IDLE) && ien;
        // DONE always exits to IDLE, so any move to DONE is a fresh completion.
        complete = (next_state == S_DONE);
    end

    // -----------------------------------------------------------------------
    // Datapath: effective request fields and byte-lane merge
    // -----------------------------------------------------------------------
    always_comb begin
        if (state == S_IDLE) begin
            eff_idx   = iaddr[ADDR_WIDTH+1:2];
            eff_we    = iwe;
            eff_be    = ibe;
            eff_wdata = iwdata;
        end else begin
            eff_idx   = idx_q;
            eff_we    = we_q;
            eff_be    = be_q;
            eff_wdata = wdata_q;
        end
        cur_word = mem[eff_idx];
        merged   = cur_word;
        if (eff_we) begin
            for (int b = 0; b < 4; b++) begin
                if (eff_be[b]) begin
                    merged[8*b +: 8] = eff_wdata[8*b +: 8];
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Request capture, wait counter and read-data register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= 4'd0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            be_q    <= 4'd0;
            wdata_q <= 32'h0;
            odata   <= 32'h0;
        end else begin
            if (accept) begin
                cnt     <= WS;
                idx_q   <= iaddr[ADDR_WIDTH+1:2];
                we_q    <= iwe;
                be_q    <= ibe;
                wdata_q <= iwdata;
            end else if (state == S_WAIT) begin
                cnt <= ien ? (cnt - 4'd1) : 4'd0;
            end
            // For reads 'merged' equals the stored word.
            if (complete) begin
                odata <= merged;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Storage array: not reset. The rst gate keeps a completion that would
    // coincide with an asserted reset from reaching the array.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (complete && eff_we && !rst) begin
            mem[eff_idx] <= merged;
        end
    end

endmodule

// File: tb/tb_de10_sram_controller.sv
// ---------------------------------------------------------------------------
// tb_de10_sram_controller
//
// Three controller instances share the request bus and reset, each with its
// own ien: WAIT_STATES = 0, 1 and 3. Expected read words are pushed to
// exp_q when a request is driven and popped when oready is seen.
// ---------------------------------------------------------------------------
module tb_de10_sram_controller;

    // ------------------------------------------------------------------ clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        ien0, ien1, ien3;
    logic [31:0] iaddr;
    logic        iwe;
    logic [3:0]  ibe;
    logic [31:0] iwdata;
    logic [31:0] odata0, odata1, odata3;
    logic        oready0, oready1, oready3;

    de10_sram_controller #(.ADDR_WIDTH(12), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .ien(ien0), .iaddr(iaddr), .iwe(iwe),
        .ibe(ibe), .iwdata(iwdata), .odata(odata0), .oready(oready0)
    );
    de10_sram_controller #(.ADDR_WIDTH(12), .WAIT_STATES(1)) dut1 (
        .clk(clk), .rst(rst), .ien(ien1), .iaddr(iaddr), .iwe(iwe),
        .ibe(ibe), .iwdata(iwdata), .odata(odata1), .oready(oready1)
    );
    de10_sram_controller #(.ADDR_WIDTH(12), .WAIT_STATES(3)) dut3 (
        .clk(clk), .rst(rst), .ien(ien3), .iaddr(iaddr), .iwe(iwe),
        .ibe(ibe), .iwdata(iwdata), .odata(odata3), .oready(oready3)
    );

    // ------------------------------------------------------------------ scoreboard
    logic [31:0] exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic set_ien(input int sel, input logic v);
        case (sel)
            0:       ien0 = v;
            1:       ien1 = v;
            default: ien3 = v;
        endcase
    endtask

    function automatic logic get_ready(input int sel);
        case (sel)
            0:       return oready0;
            1:       return oready1;
            default: return oready3;
        endcase
    endfunction

    function automatic logic [31:0] get_data(input int sel);
        case (sel)
            0:       return odata0;
            1:       return odata1;
            default: return odata3;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] be,
                                          input logic [31:0] wd);
        logic [31:0] r;
        r = old;
        if (be[0]) r[7:0]   = wd[7:0];
        if (be[1]) r[15:8]  = wd[15:8];
        if (be[2]) r[23:16] = wd[23:16];
        if (be[3]) r[31:24] = wd[31:24];
        return r;
    endfunction

    // ------------------------------------------------------------------ driver
    // One full access on instance 'sel' (its WAIT_STATES equals sel).
    // Request fields are scrambled after acceptance to show they are latched.
    task automatic access(input int sel, input logic we, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wd,
                          input logic [31:0] exp, input string name);
        int          lat;
        bit          seen;
        logic [31:0] e;
        lat  = sel + 1;
        seen = 1'b0;
        @(negedge clk);
        iwe = we; iaddr = addr; ibe = be; iwdata = wd;
        set_ien(sel, 1'b1);
        exp_q.push_back(exp);
        for (int n = 1; n <= 20 && !seen; n++) begin
            @(negedge clk);
            if (get_ready(sel)) begin
                seen = 1'b1;
                check($sformatf("%s latency", name), 32'(n), 32'(lat));
                e = exp_q.pop_front();
                check($sformatf("%s data", name), get_data(sel), e);
            end
            if (n == 1) begin
                iaddr  = $urandom;
                iwdata = $urandom;
                ibe    = 4'($urandom_range(0, 15));
                iwe    = 1'($urandom_range(0, 1));
            end
        end
        set_ien(sel, 1'b0);
        if (!seen) begin
            n_checks++;
            $display("FAIL %s timeout: no oready within 20 cycles, required at cycle %0d", name, lat);
            void'(exp_q.pop_front());
        end
    endtask

    // ------------------------------------------------------------------ vector table
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs[11];
    logic [31:0] model[8];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin : main
        logic        we;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] ex;
        int          k;

        vecs[0]  = '{1'b1, 32'h0000_0010, 4'hF, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[1]  = '{1'b0, 32'h0000_0010, 4'h0, 32'h0,        32'hDEADBEEF};
        vecs[2]  = '{1'b1, 32'h0000_0010, 4'h5, 32'h11223344, 32'hDE22BE44};
        vecs[3]  = '{1'b0, 32'h0000_0010, 4'hF, 32'h0,        32'hDE22BE44};
        vecs[4]  = '{1'b1, 32'h0000_4000, 4'hF, 32'hA5A5A5A5, 32'hA5A5A5A5};
        vecs[5]  = '{1'b0, 32'h0000_0003, 4'h0, 32'h0,        32'hA5A5A5A5};
        vecs[6]  = '{1'b1, 32'h0000_0010, 4'h0, 32'hFFFFFFFF, 32'hDE22BE44};
        vecs[7]  = '{1'b0, 32'h0000_0013, 4'h0, 32'h0,        32'hDE22BE44};
        vecs[8]  = '{1'b1, 32'h0000_0024, 4'hF, 32'h01020304, 32'h01020304};
        vecs[9]  = '{1'b1, 32'h0000_0024, 4'hA, 32'hFFFFFFFF, 32'hFF02FF04};
        vecs[10] = '{1'b0, 32'hFFC0_0026, 4'h0, 32'h0,        32'hFF02FF04};

        // ---------------------------------------------------------- reset + idle
        rst = 1'b1; ien0 = 1'b0; ien1 = 1'b0; ien3 = 1'b0;
        iaddr = 32'h0; iwe = 1'b0; ibe = 4'h0; iwdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            for (int s = 0; s < 4; s += (s == 1) ? 2 : 1) begin
                check($sformatf("idle c%0d oready%0d", c, s), 32'(get_ready(s)), 32'h0);
                check($sformatf("idle c%0d odata%0d", c, s), get_data(s), 32'h0);
            end
        end

        // ---------------------------------------------------------- table on WAIT_STATES=1
        for (int i = 0; i < 11; i++) begin
            access(1, vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wd, vecs[i].exp,
                   $sformatf("vec%0d", i));
        end

        // ---------------------------------------------------------- randomized with model
        for (int i = 0; i < 8; i++) begin
            model[i] = $urandom;
            access(1, 1'b1, 32'h400 + 32'(4 * i), 4'hF, model[i], model[i],
                   $sformatf("rinit%0d", i));
        end
        for (int i = 0; i < 12; i++) begin
            k  = $urandom_range(0, 7);
            we = 1'($urandom_range(0, 1));
            be = 4'($urandom_range(0, 15));
            wd = $urandom;
            if (we) model[k] = merge(model[k], be, wd);
            ex = model[k];
            access(1, we, 32'h400 + 32'(4 * k) + 32'($urandom_range(0, 3)), be, wd, ex,
                   $sformatf("rand%0d", i));
        end

        // ---------------------------------------------------------- abort on WAIT_STATES=3
        access(3, 1'b1, 32'h20, 4'hF, 32'h0BADF00D, 32'h0BADF00D, "abort prior");
        @(negedge clk);
        iwe = 1'b1; iaddr = 32'h20; ibe = 4'hF; iwdata = 32'h12345678; ien3 = 1'b1;
        @(negedge clk);
        check("abort wait1 oready", 32'(oready3), 32'h0);
        @(negedge clk);
        check("abort wait2 oready", 32'(oready3), 32'h0);
        ien3 = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check($sformatf("abort c%0d oready", c), 32'(oready3), 32'h0);
            check($sformatf("abort c%0d odata", c), odata3, 32'h0BADF00D);
        end
        access(3, 1'b0, 32'h20, 4'h0, 32'h0, 32'h0BADF00D, "abort readback");

        // ---------------------------------------------------------- back-to-back, WAIT_STATES=0
        access(0, 1'b1, 32'h30, 4'hF, 32'h0000_0055, 32'h0000_0055, "b2b prior");
        @(negedge clk);
        iwe = 1'b0; iaddr = 32'h30; ibe = 4'h0; iwdata = 32'h0; ien0 = 1'b1;
        repeat (3) exp_q.push_back(32'h0000_0055);
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            check($sformatf("b2b cycle%0d oready", n), 32'(oready0), 32'(n % 2));
            if (oready0) check($sformatf("b2b cycle%0d odata", n), odata0, exp_q.pop_front());
            if (n == 5) ien0 = 1'b0;
        end

        // ---------------------------------------------------------- reset mid-write
        access(3, 1'b1, 32'h40, 4'hF, 32'h77777777, 32'h77777777, "rst prior");
        @(negedge clk);
        iwe = 1'b1; iaddr = 32'h40; ibe = 4'hF; iwdata = 32'h88888888; ien3 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst async oready", 32'(oready3), 32'h0);
        check("rst async odata", odata3, 32'h0);
        check("rst async odata other", odata1, 32'h0);
        @(negedge clk);
        check("rst held oready", 32'(oready3), 32'h0);
        check("rst held odata", odata3, 32'h0);
        rst = 1'b0; ien3 = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("post rst c%0d oready", c), 32'(oready3), 32'h0);
        end
        access(3, 1'b0, 32'h40, 4'h0, 32'h0, 32'h77777777, "rst readback");
        access(1, 1'b0, 32'h10, 4'h0, 32'h0, 32'hDE22BE44, "rst keeps array");

        check("scoreboard drained", 32'(exp_q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
